// File: rtl/parallel_to_series_fsk.sv
// parallel_to_series_fsk
//   Double-buffered 16-bit parallel-to-serial transmitter. A word is captured
//   into a holding register on an accepted load strobe and moved into the
//   shift register as soon as the shifter is free. Bits leave LSB first, each
//   held for BIT_CYCLES clocks. Back-to-back frames run with no idle gap.
//
//   Optional feature: define FSK_TX_PREAMBLE_EN to precede every frame with
//   the sync pattern 1,0,1,0 (BIT_CYCLES clocks per sync bit, state PRE).
//
// Parameters
//   BIT_CYCLES   clk_16 cycles per bit (1..16)
//   IDLE_LEVEL   sig_send level between frames
// Ports
//   clk_16       clock, all state on rising edge
//   reset        asynchronous, active-high
//   sig_par      parallel word, sampled only on an accepted load
//   trans_enable load strobe
//   sig_send     registered serial data, LSB first
//   busy         high while a frame (preamble or data) is on sig_send
//   ready        high when the holding register is empty
//   frame_done   one-cycle pulse after the last bit period of a frame
//   overrun      sticky: a load arrived while the holding register was full
module parallel_to_series_fsk #(
  parameter int   BIT_CYCLES = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic        clk_16,
  input  logic        reset,
  input  logic [15:0] sig_par,
  input  logic        trans_enable,
  output logic        sig_send,
  output logic        busy,
  output logic        ready,
  output logic        frame_done,
  output logic        overrun
);

  localparam int             CW   = $clog2(BIT_CYCLES + 1);
  localparam logic [CW-1:0]  LAST = CW'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1
`ifdef FSK_TX_PREAMBLE_EN
    ,
    S_PRE   = 2'd2
`endif
  } state_t;

  state_t        state;
  logic [15:0]   hold;
  logic [15:0]   shifter;
  logic [CW-1:0] bit_cnt;
  logic [3:0]    bit_idx;
`ifdef FSK_TX_PREAMBLE_EN
  logic [1:0]    pre_idx;
`endif

  // Final clock of bit 15: the shifter becomes free on the next edge.
  logic frame_end;
  assign frame_end = (state == S_SHIFT) && (bit_cnt == LAST) && (bit_idx == 4'd15);

  always_ff @(posedge clk_16 or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      hold       <= '0;
      shifter    <= '0;
      bit_cnt    <= '0;
      bit_idx    <= '0;
`ifdef FSK_TX_PREAMBLE_EN
      pre_idx    <= '0;
`endif
      sig_send   <= IDLE_LEVEL;
      busy       <= 1'b0;
      ready      <= 1'b1;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      // Load side. ready is registered, so a load on the same edge the hold
      // word moves to the shifter still sees ready=0 and counts as overrun.
      if (trans_enable) begin
        if (ready) begin
          hold  <= sig_par;
          ready <= 1'b0;
        end else begin
          overrun <= 1'b1;
        end
      end

      if (state == S_IDLE || frame_end) begin
        if (frame_end) frame_done <= 1'b1;
        bit_cnt <= '0;
        if (!ready) begin
          // Hold valid: start the next frame with no gap.
          shifter <= hold;
          ready   <= 1'b1;
          busy    <= 1'b1;
          bit_idx <= '0;
`ifdef FSK_TX_PREAMBLE_EN
          state    <= S_PRE;
          pre_idx  <= '0;
          sig_send <= 1'b1;
`else
          state    <= S_SHIFT;
          sig_send <= hold[0];
`endif
        end else begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          sig_send <= IDLE_LEVEL;
        end
      end else if (bit_cnt != LAST) begin
        bit_cnt <= bit_cnt + CW'(1);
      end else begin
        bit_cnt <= '0;
`ifdef FSK_TX_PREAMBLE_EN
        if (state == S_PRE) begin
          if (pre_idx == 2'd3) begin
            state    <= S_SHIFT;
            sig_send <= shifter[0];
          end else begin
            pre_idx  <= pre_idx + 2'd1;
            // Sync bit k is ~k[0]; next one is therefore the current pre_idx[0].
            sig_send <= pre_idx[0];
          end
        end else begin
          bit_idx  <= bit_idx + 4'd1;
          shifter  <= {1'b0, shifter[15:1]};
          sig_send <= shifter[1];
        end
`else
        bit_idx  <= bit_idx + 4'd1;
        shifter  <= {1'b0, shifter[15:1]};
        sig_send <= shifter[1];
`endif
      end
    end
  end

endmodule

// File: tb/tb_parallel_to_series_fsk.sv
module tb_parallel_to_series_fsk;

`ifdef FSK_TX_PREAMBLE_EN
  localparam int BC      = 4;
  localparam int PRE_LEN = 4;
`else
  localparam int BC      = 1;
  localparam int PRE_LEN = 0;
`endif
  localparam logic IDLE  = 1'b0;
  localparam int   FLEN  = (PRE_LEN + 16) * BC;

  logic        clk_16 = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] sig_par = 16'h0;
  logic        trans_enable = 1'b0;
  logic        sig_send, busy, ready, frame_done, overrun;

  parallel_to_series_fsk #(.BIT_CYCLES(BC), .IDLE_LEVEL(IDLE)) dut (
    .clk_16(clk_16), .reset(reset), .sig_par(sig_par), .trans_enable(trans_enable),
    .sig_send(sig_send), .busy(busy), .ready(ready), .frame_done(frame_done),
    .overrun(overrun)
  );

  always #5 clk_16 = ~clk_16;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
  endtask

  // ---------------- reference model ----------------
  // Frame = list of per-clock line values; hold = at most one waiting word.
  logic        cur[$];
  logic [4:0]  exp_q[$];       // {sig_send,busy,ready,frame_done,overrun}
  logic [15:0] exp_words[$];   // words that should appear on the line, in order
  logic        m_ready, m_ovr;
  logic [15:0] m_hold;

  function automatic void start_frame(input logic [15:0] w);
    cur.delete();
    for (int p = 0; p < PRE_LEN; p++)
      for (int c = 0; c < BC; c++) cur.push_back((p % 2) == 0);
    for (int i = 0; i < 16; i++)
      for (int c = 0; c < BC; c++) cur.push_back(w[i]);
  endfunction

  initial forever begin
    @(posedge clk_16 or posedge reset);
    if (reset) begin
      cur.delete(); exp_q.delete(); exp_words.delete();
      m_ready = 1'b1; m_ovr = 1'b0; m_hold = 16'h0;
    end else begin
      logic fd, was_ready, transfer, b, s;
      fd = 1'b0; transfer = 1'b0; was_ready = m_ready;
      if (cur.size() > 1) void'(cur.pop_front());
      else begin
        if (cur.size() == 1) begin fd = 1'b1; void'(cur.pop_front()); end
        if (!was_ready) begin start_frame(m_hold); transfer = 1'b1; end
      end
      b = (cur.size() > 0);
      s = b ? cur[0] : IDLE;
      if (trans_enable) begin
        if (was_ready) begin
          m_hold = sig_par; m_ready = 1'b0; exp_words.push_back(sig_par);
        end else m_ovr = 1'b1;
      end
      if (transfer) m_ready = 1'b1;
      exp_q.push_back({s, b, m_ready, fd, m_ovr});
    end
  end

  // ---------------- monitor ----------------
  logic fr[$];   // line samples of the frame in progress

  initial forever begin
    @(negedge clk_16);
    if (reset) begin
      chk("reset_outputs", {27'd0, sig_send, busy, ready, frame_done, overrun},
          {27'd0, IDLE, 1'b0, 1'b1, 1'b0, 1'b0});
      fr.delete();
    end else begin
      if (exp_q.size() == 0) chk("expect_available", 0, 1);
      else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        chk("cycle_outputs", {27'd0, sig_send, busy, ready, frame_done, overrun}, {27'd0, e});
      end
      if (frame_done) begin
        chk("frame_length", fr.size(), FLEN);
        if (fr.size() == FLEN) begin
          logic [15:0] w;
          logic [3:0]  pre, pre_exp;
          pre = '0; pre_exp = 4'b0101;  // sync bits 1,0,1,0 read LSB first
          for (int p = 0; p < PRE_LEN; p++) pre[p] = fr[p * BC];
          if (PRE_LEN > 0) chk("preamble", pre, pre_exp);
          for (int i = 0; i < 16; i++) w[i] = fr[(PRE_LEN + i) * BC];
          if (exp_words.size() == 0) chk("word_expected", 0, 1);
          else chk("frame_word", w, exp_words.pop_front());
        end
        fr.delete();
      end
      if (busy) fr.push_back(sig_send);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk_16); #1;
  endtask

  task automatic load(input logic [15:0] w);
    trans_enable = 1'b1; sig_par = w;
    tick();
    trans_enable = 1'b0; sig_par = 16'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    #1 reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(2);

    // single frame
    load(16'hA5C3);
    idle(FLEN + 6);

    // second word arrives while first is shifting: contiguous frames
    load(16'h0001);
    idle(4);
    load(16'hFFFF);
    idle(2 * FLEN + 6);

    // loads on consecutive edges: those that find hold full are dropped
    load(16'h1234);
    load(16'h5678);
    load(16'h9ABC);
    load(16'hDEF0);
    idle(3 * FLEN + 6);

    // reset during bit 7 aborts the frame immediately
    load(16'h3C3C);
    idle((PRE_LEN + 7) * BC + 1);
    reset = 1'b1;
    #1;
    chk("async_reset_immediate", {29'd0, sig_send, busy, frame_done}, {29'd0, IDLE, 2'b00});
    idle(2);
    reset = 1'b0;
    idle(1);
    load(16'h8000);
    idle(FLEN + 6);

    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        reset = 1'b1; tick(); reset = 1'b0;
      end else if ($urandom_range(0, 3) == 0) load(16'($urandom));
      else tick();
    end
    idle(2 * FLEN + 8);
    chk("all_words_sent", exp_words.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
